// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the M-stage data-memory responder:
//   - funct3 load codes and byte-lane enable codes
//   - FSM state encoding
//   - access_err(): misalignment / illegal-encoding check
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

  // Load size/sign selectors (funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Unshifted byte-lane write enables; BE_NONE marks a load
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B    = 4'b0001;
  localparam logic [3:0] BE_H    = 4'b0011;
  localparam logic [3:0] BE_W    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Stores take their access size from the lane enables, loads from funct3.
  // Any encoding outside the legal sets is flagged as an error.
  function automatic logic access_err(input logic [3:0] we,
                                      input logic [2:0] f3,
                                      input logic [1:0] off);
    logic err_s;
    err_s = 1'b0;
    if (we != BE_NONE) begin
      case (we)
        BE_B:    err_s = 1'b0;
        BE_H:    err_s = off[0];
        BE_W:    err_s = (off != 2'b00);
        default: err_s = 1'b1;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: err_s = 1'b0;
        F3_LH, F3_LHU: err_s = off[0];
        F3_LW:         err_s = (off != 2'b00);
        default:       err_s = 1'b1;
      endcase
    end
    return err_s;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bundle between the pipeline controller (master) and the
// data-memory responder (slave).
//   req_valid/req_we/req_addr/req_wdata/req_f3 : controller -> responder
//   req_ready/stall_req                          : responder -> controller
//   resp_valid/resp_rdata/resp_err               : responder -> controller
// -----------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid;
  logic [3:0]  req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_f3;
  logic        req_ready;
  logic        stall_req;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_f3,
    input  req_ready, stall_req, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_f3,
    output req_ready, stall_req, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_load_align.sv
// -----------------------------------------------------------------------------
// dmem_load_align
// Purely combinational load formatter: selects the byte/half addressed by
// off and sign- or zero-extends it according to funct3.
//   word  in  32 : raw array word
//   off   in   2 : byte offset (addr[1:0])
//   f3    in   3 : load funct3
//   rdata out 32 : formatted load data (0 for unknown funct3)
// -----------------------------------------------------------------------------
module dmem_load_align
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  f3,
  output logic [31:0] rdata
);

  logic [31:0] shifted_s;

  // Bring the addressed lane down to bit 0, then extend by load type.
  always_comb begin
    shifted_s = word >> {off, 3'b000};
    case (f3)
      F3_LB:   rdata = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_LH:   rdata = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_LW:   rdata = word;
      F3_LBU:  rdata = {24'd0, shifted_s[7:0]};
      F3_LHU:  rdata = {16'd0, shifted_s[15:0]};
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// M-stage data-memory responder. Accepts one load/store in IDLE, waits
// LATENCY cycles, performs the array access on the edge entering DONE and
// pulses resp_valid for one cycle with formatted load data.
//   clk  in  : clock, rising edge
//   rst  in  : synchronous, active-low reset
//   bus  slave modport of dmem_responder_if (request, stall, response)
// Parameters:
//   ADDR_W  : byte-address bits used (array = 2^(ADDR_W-2) words, upper bits wrap)
//   LATENCY : cycles from acceptance to response, 1..15
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input logic            clk,
  input logic            rst,
  dmem_responder_if.slave bus
);

  localparam int         DEPTH        = 2 ** (ADDR_W - 2);
  localparam bit         SINGLE_CYCLE = (LATENCY == 1);
  localparam logic [3:0] CNT_INIT     = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  logic [31:0] mem_r [0:DEPTH-1];

  state_e              state_r;
  logic [3:0]          cnt_r;
  logic [3:0]          cap_we_r;
  logic [ADDR_W-1:0]   cap_addr_r;
  logic [31:0]         cap_wdata_r;
  logic [2:0]          cap_f3_r;
  logic                cap_err_r;
  logic                ready_r;
  logic                busy_r;
  logic                resp_valid_r;
  logic [31:0]         resp_rdata_r;
  logic                resp_err_r;

  logic                accept_s;
  logic                live_err_s;
  logic [3:0]          cur_we_s;
  logic [ADDR_W-1:0]   cur_addr_s;
  logic [31:0]         cur_wdata_s;
  logic [2:0]          cur_f3_s;
  logic                cur_err_s;
  logic                enter_done_s;
  logic [ADDR_W-3:0]   cur_idx_s;
  logic [3:0]          lane_we_s;
  logic [31:0]         lane_wd_s;
  logic [31:0]         word_s;
  logic [31:0]         fmt_s;
  logic [31:0]         resp_data_s;
  logic                unused_addr_s;

  // Address bits above ADDR_W wrap and are deliberately ignored.
  assign unused_addr_s = ^bus.req_addr[31:ADDR_W];

  assign accept_s   = bus.req_valid & ready_r;
  assign live_err_s = access_err(bus.req_we, bus.req_f3, bus.req_addr[1:0]);

  // Request fields seen by the array: with LATENCY=1 the access lands on the
  // acceptance edge itself, so the live bus fields are used in IDLE.
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_we_s    = bus.req_we;
      cur_addr_s  = bus.req_addr[ADDR_W-1:0];
      cur_wdata_s = bus.req_wdata;
      cur_f3_s    = bus.req_f3;
      cur_err_s   = live_err_s;
    end else begin
      cur_we_s    = cap_we_r;
      cur_addr_s  = cap_addr_r;
      cur_wdata_s = cap_wdata_r;
      cur_f3_s    = cap_f3_r;
      cur_err_s   = cap_err_r;
    end
  end

  // Marks the edge on which the FSM enters DONE (array access edge).
  always_comb begin
    case (state_r)
      ST_IDLE: enter_done_s = SINGLE_CYCLE && accept_s;
      ST_BUSY: enter_done_s = (cnt_r == 4'd0);
      default: enter_done_s = 1'b0;
    endcase
  end

  assign cur_idx_s = cur_addr_s[ADDR_W-1:2];
  assign lane_we_s = cur_we_s << cur_addr_s[1:0];
  assign lane_wd_s = cur_wdata_s << {cur_addr_s[1:0], 3'b000};
  assign word_s    = mem_r[cur_idx_s];

  dmem_load_align u_align (
    .word  (word_s),
    .off   (cur_addr_s[1:0]),
    .f3    (cur_f3_s),
    .rdata (fmt_s)
  );

  // Stores and faulting accesses return zero data.
  assign resp_data_s = (cur_err_s || (cur_we_s != BE_NONE)) ? 32'd0 : fmt_s;

  // Array write on the DONE-entry edge; reset suppresses a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst && enter_done_s && !cur_err_s) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_we_s[k]) begin
          mem_r[cur_idx_s][8*k +: 8] <= lane_wd_s[8*k +: 8];
        end
      end
    end
  end

  // Control FSM: state, latency counter, captured request and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      cap_we_r     <= 4'd0;
      cap_addr_r   <= '0;
      cap_wdata_r  <= 32'd0;
      cap_f3_r     <= 3'd0;
      cap_err_r    <= 1'b0;
      ready_r      <= 1'b1;
      busy_r       <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            cap_we_r    <= bus.req_we;
            cap_addr_r  <= bus.req_addr[ADDR_W-1:0];
            cap_wdata_r <= bus.req_wdata;
            cap_f3_r    <= bus.req_f3;
            cap_err_r   <= live_err_s;
            ready_r     <= 1'b0;
            if (SINGLE_CYCLE) begin
              state_r      <= ST_DONE;
              busy_r       <= 1'b0;
              resp_valid_r <= 1'b1;
              resp_rdata_r <= resp_data_s;
              resp_err_r   <= live_err_s;
            end else begin
              state_r <= ST_BUSY;
              cnt_r   <= CNT_INIT;
              busy_r  <= 1'b1;
            end
          end else begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (cnt_r == 4'd0) begin
            state_r      <= ST_DONE;
            busy_r       <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_rdata_r <= resp_data_s;
            resp_err_r   <= cap_err_r;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_DONE: begin
          state_r      <= ST_IDLE;
          ready_r      <= 1'b1;
          busy_r       <= 1'b0;
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 32'd0;
          resp_err_r   <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          cnt_r        <= 4'd0;
          ready_r      <= 1'b1;
          busy_r       <= 1'b0;
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 32'd0;
          resp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_r;
  // Only IDLE forwards req_valid to the stall; BUSY always stalls, DONE never does.
  assign bus.stall_req  = (ready_r & bus.req_valid) | busy_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;

endmodule
